// File: rtl/cdb_arbiter.sv
// Common data bus transmitter: per-source result FIFOs feeding two registered broadcast
// lanes, with rotating round-robin selection of up to two distinct sources per cycle.
module cdb_arbiter #(
    parameter int unsigned N_SRC      = 5,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned PADDR_W    = 7,
    parameter int unsigned AADDR_W    = 5,
    localparam int unsigned PKT_W     = 1 + PADDR_W + AADDR_W + 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush,
    input  logic [N_SRC-1:0]                src_valid,
    output logic [N_SRC-1:0]                src_ready,
    input  logic [N_SRC-1:0][PADDR_W-1:0]   src_paddr,
    input  logic [N_SRC-1:0][AADDR_W-1:0]   src_aaddr,
    input  logic [N_SRC-1:0][31:0]          src_rd,
    output logic [PKT_W-1:0]                cdb_pkt,
    output logic [PKT_W-1:0]                cdb_pkt2
);

    localparam int unsigned ENTRY_W = PADDR_W + AADDR_W + 32;
    localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SRC_W   = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    // Packed layout on the ports: {cdb_broadcast, cdb_p_addr, cdb_aaddr, cdb_rd}.
    typedef struct packed {
        logic               cdb_broadcast;
        logic [PADDR_W-1:0] cdb_p_addr;
        logic [AADDR_W-1:0] cdb_aaddr;
        logic [31:0]        cdb_rd;
    } cdb_pkt_t;

    logic [ENTRY_W-1:0]            mem_q [N_SRC][FIFO_DEPTH];
    logic [N_SRC-1:0][CNT_W-1:0]   count_q, count_d;
    logic [N_SRC-1:0][PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
    logic [SRC_W-1:0]              rr_ptr_q, rr_ptr_d;
    cdb_pkt_t                      pkt_q, pkt_d, pkt2_q, pkt2_d;

    logic [N_SRC-1:0]   nonempty, push, pop;
    logic [ENTRY_W-1:0] head [N_SRC];
    logic               g0_vld, g1_vld;
    logic [SRC_W-1:0]   g0_idx, g1_idx;

    function automatic logic [SRC_W-1:0] next_idx(input logic [SRC_W-1:0] idx);
        return (idx == SRC_W'(N_SRC - 1)) ? '0 : idx + SRC_W'(1);
    endfunction

    // Ready looks only at the registered count, so a full FIFO stays closed while popping.
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            nonempty[i]  = (count_q[i] != '0);
            src_ready[i] = rst_n && !flush && (count_q[i] != CNT_W'(FIFO_DEPTH));
            push[i]      = src_valid[i] && src_ready[i];
            head[i]      = mem_q[i][rd_ptr_q[i]];
        end
    end

    always_comb begin
        int unsigned      scan;
        logic [SRC_W-1:0] scan_idx;
        scan     = 0;
        scan_idx = '0;
        g0_vld   = 1'b0;
        g1_vld   = 1'b0;
        g0_idx   = '0;
        g1_idx   = '0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            scan     = (32'(rr_ptr_q) + k) % N_SRC;
            scan_idx = SRC_W'(scan);
            if (nonempty[scan_idx]) begin
                if (!g0_vld) begin
                    g0_vld = 1'b1;
                    g0_idx = scan_idx;
                end else if (!g1_vld) begin
                    g1_vld = 1'b1;
                    g1_idx = scan_idx;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            pop[i] = (g0_vld && (g0_idx == SRC_W'(i))) || (g1_vld && (g1_idx == SRC_W'(i)));
            unique case ({push[i], pop[i]})
                2'b10:   count_d[i] = count_q[i] + CNT_W'(1);
                2'b01:   count_d[i] = count_q[i] - CNT_W'(1);
                default: count_d[i] = count_q[i];
            endcase
        end
    end

    always_comb begin
        pkt_d    = '0;
        pkt2_d   = '0;
        rr_ptr_d = rr_ptr_q;
        if (g0_vld) begin
            pkt_d    = {1'b1, head[g0_idx]};
            rr_ptr_d = next_idx(g0_idx);
        end
        if (g1_vld) begin
            pkt2_d   = {1'b1, head[g1_idx]};
            rr_ptr_d = next_idx(g1_idx);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            rr_ptr_q <= '0;
            pkt_q    <= '0;
            pkt2_q   <= '0;
        end else if (flush) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            rr_ptr_q <= '0;
            pkt_q    <= '0;
            pkt2_q   <= '0;
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PTR_W'(1);
                if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + PTR_W'(1);
            end
            count_q  <= count_d;
            rr_ptr_q <= rr_ptr_d;
            pkt_q    <= pkt_d;
            pkt2_q   <= pkt2_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the counters.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_SRC; i++) begin
            if (push[i]) mem_q[i][wr_ptr_q[i]] <= {src_paddr[i], src_aaddr[i], src_rd[i]};
        end
    end

    assign cdb_pkt  = pkt_q;
    assign cdb_pkt2 = pkt2_q;

endmodule
